opregfile: RTL

OPREGFILE -- requirements
Module: opregfile

---
 rtl/opregfile.sv | 111 +++++++++++
 1 files changed

// File: rtl/opregfile.sv
// opregfile: small register file with a single-operand ALU on the read port.
//
// Each cycle with i_w_oe=1, the register at i_w_raddr (value held before the
// edge) is passed through the operation selected by i_w_opsel. The result is
// registered onto o_w_out with o_w_valid/o_w_zero/o_w_carry one edge later.
// With i_w_wb=1 the result is also written back to the read address.
//
// Ports:
//   i_w_clk    sole clock, rising edge
//   i_w_reset  synchronous active-low reset
//   i_w_data   write data (WIDTH)
//   i_w_we     write enable, stores i_w_data into reg[i_w_waddr]
//   i_w_waddr  write address (AW)
//   i_w_oe     read/operate request
//   i_w_raddr  read address (AW)
//   i_w_opsel  operation select (3)
//   i_w_wb     write-back enable (only with i_w_oe)
//   o_w_out    registered result (holds over idle cycles)
//   o_w_valid  one-cycle pulse per accepted request
//   o_w_zero   result is zero (only while valid)
//   o_w_carry  carry/borrow of increment/decrement (only while valid)
module opregfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_w_clk,
    input  logic             i_w_reset,
    input  logic [WIDTH-1:0] i_w_data,
    input  logic             i_w_we,
    input  logic [AW-1:0]    i_w_waddr,
    input  logic             i_w_oe,
    input  logic [AW-1:0]    i_w_raddr,
    input  logic [2:0]       i_w_opsel,
    input  logic             i_w_wb,
    output logic [WIDTH-1:0] o_w_out,
    output logic             o_w_valid,
    output logic             o_w_zero,
    output logic             o_w_carry
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;

    assign operand = regs_q[i_w_raddr];

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        case (i_w_opsel)
            3'd0: result_d = operand;
            3'd1: result_d = ~operand;
            3'd2: result_d = {operand[WIDTH-2:0], operand[WIDTH-1]};
            3'd3: result_d = {operand[0], operand[WIDTH-1:1]};
            3'd4: begin
                result_d = operand + WIDTH'(1);
                carry_d  = &operand;
            end
            3'd5: begin
                result_d = operand - WIDTH'(1);
                carry_d  = ~|operand;
            end
            3'd6: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    result_d[i] = operand[WIDTH-1-i];
                end
            end
            default: result_d = '0;
        endcase
    end

    // Storage. The external write is issued after write-back so it wins on a
    // same-address collision.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (i_w_oe && i_w_wb) begin
                regs_q[i_w_raddr] <= result_d;
            end
            if (i_w_we) begin
                regs_q[i_w_waddr] <= i_w_data;
            end
        end
    end

    // Result stage. o_w_out keeps the last result across idle cycles; flags
    // are only meaningful alongside the valid pulse.
    always_ff @(posedge i_w_clk) begin
        if (!i_w_reset) begin
            o_w_out   <= '0;
            o_w_valid <= 1'b0;
            o_w_zero  <= 1'b0;
            o_w_carry <= 1'b0;
        end else if (i_w_oe) begin
            o_w_out   <= result_d;
            o_w_valid <= 1'b1;
            o_w_zero  <= (result_d == '0);
            o_w_carry <= carry_d;
        end else begin
            o_w_valid <= 1'b0;
            o_w_zero  <= 1'b0;
            o_w_carry <= 1'b0;
        end
    end

endmodule
